// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel mux with fixed-select or round-robin grant into a single registered output stage
//   clk, rst        : clock, synchronous active-high reset
//   In, InValid     : flattened channel data (channel i at [i*WIDTH +: WIDTH]) and per-channel valid
//   InReady         : one-hot (or zero) combinational ready to the granted channel
//   Mode, Sel       : 0 = take channel Sel, 1 = round-robin after last granted channel
//   Out, OutSel     : registered data and source channel index
//   OutValid, OutReady : output handshake
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   In,
  input  logic [N-1:0]         InValid,
  output logic [N-1:0]         InReady,
  input  logic                 Mode,
  input  logic [SELW-1:0]      Sel,
  output logic [WIDTH-1:0]     Out,
  output logic [SELW-1:0]      OutSel,
  output logic                 OutValid,
  input  logic                 OutReady
);
  logic [WIDTH-1:0] out_q;
  logic [SELW-1:0]  out_sel_q, ptr_q, gnt_idx, rr_idx;
  logic             out_valid_q, ld, gnt_v, rr_v, fix_v;
  assign ld = !out_valid_q || OutReady;
  // Sel may encode indices past N-1 when N is not a power of two; those never grant.
  assign fix_v = (int'(Sel) < N) && InValid[Sel];
  // Search ptr+1 .. ptr+N modulo N so the last-granted channel is considered last.
  always_comb begin
    rr_v = 1'b0;
    rr_idx = '0;
    for (int i = 1; i <= N; i++) begin
      int k;
      k = int'(ptr_q) + i;
      k = (k >= N) ? k - N : k;
      if (!rr_v && InValid[k]) begin
        rr_v = 1'b1;
        rr_idx = SELW'(k);
      end
    end
  end
  assign gnt_v = Mode ? rr_v : fix_v;
  assign gnt_idx = Mode ? rr_idx : Sel;
  always_comb begin
    InReady = '0;
    if (!rst && ld && gnt_v) InReady[gnt_idx] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      out_sel_q <= '0;
      out_valid_q <= 1'b0;
      ptr_q <= SELW'(N - 1);
    end else if (ld) begin
      out_valid_q <= gnt_v;
      if (gnt_v) begin
        out_q <= In[gnt_idx*WIDTH +: WIDTH];
        out_sel_q <= gnt_idx;
        ptr_q <= gnt_idx;
      end
    end
  end
  assign Out = out_q;
  assign OutSel = out_sel_q;
  assign OutValid = out_valid_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed self-checking bench for rr_arb_mux at N=8, WIDTH=32
module tb_rr_arb_mux;
  localparam int W = 32;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst;
  logic [N*W-1:0] in_bus;
  logic [N-1:0] in_valid, in_ready;
  logic mode, out_ready, out_valid;
  logic [2:0] sel, out_sel;
  logic [W-1:0] out_d;
  logic [W-1:0] data [N];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  always_comb for (int i = 0; i < N; i++) in_bus[i*W +: W] = data[i];
  rr_arb_mux #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .In(in_bus), .InValid(in_valid), .InReady(in_ready),
    .Mode(mode), .Sel(sel), .Out(out_d), .OutSel(out_sel), .OutValid(out_valid),
    .OutReady(out_ready)
  );
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  initial begin
    for (int i = 0; i < N; i++) data[i] = 32'hA000_0000 + i;
    rst = 1'b1; mode = 1'b1; sel = '0; in_valid = 8'hFF; out_ready = 1'b1;
    settle();
    chk("rst_inready", 32'(in_ready), 32'h0);
    step();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_out", out_d, 32'h0);
    chk("rst_sel", 32'(out_sel), 32'h0);
    rst = 1'b0;
    settle();
    chk("rr_first_ready", 32'(in_ready), 32'h01);
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("rr_seq%0d_sel", k), 32'(out_sel), 32'(k % N));
      chk($sformatf("rr_seq%0d_out", k), out_d, 32'hA000_0000 + (k % N));
      chk($sformatf("rr_seq%0d_valid", k), 32'(out_valid), 32'h1);
    end
    in_valid = 8'b1000_0001;
    settle();
    chk("alt_ready", 32'(in_ready), 32'h80);
    step();
    chk("alt0_sel", 32'(out_sel), 32'd7);
    step();
    chk("alt1_sel", 32'(out_sel), 32'd0);
    step();
    chk("alt2_sel", 32'(out_sel), 32'd7);
    mode = 1'b0; sel = 3'd3; in_valid = 8'h08;
    settle();
    chk("fix_ready", 32'(in_ready), 32'h08);
    step();
    chk("fix_out", out_d, 32'hA000_0003);
    out_ready = 1'b0;
    data[3] = 32'h3333_0003;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("stall%0d_ready", k), 32'(in_ready), 32'h0);
      step();
      chk($sformatf("stall%0d_out", k), out_d, 32'hA000_0003);
      chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    settle();
    chk("unstall_ready", 32'(in_ready), 32'h08);
    step();
    chk("unstall_out", out_d, 32'h3333_0003);
    chk("unstall_sel", 32'(out_sel), 32'd3);
    sel = 3'd5; in_valid = 8'hDF;
    settle();
    chk("nogrant_ready", 32'(in_ready), 32'h0);
    step();
    chk("nogrant_valid", 32'(out_valid), 32'h0);
    chk("nogrant_out_hold", out_d, 32'h3333_0003);
    chk("nogrant_sel_hold", 32'(out_sel), 32'd3);
    mode = 1'b1; in_valid = 8'hFF;
    step();
    chk("stream0_sel", 32'(out_sel), 32'd4);
    step();
    chk("stream1_sel", 32'(out_sel), 32'd5);
    rst = 1'b1;
    settle();
    chk("midrst_ready", 32'(in_ready), 32'h0);
    step();
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_out", out_d, 32'h0);
    rst = 1'b0;
    settle();
    chk("postrst_ready", 32'(in_ready), 32'h01);
    step();
    chk("postrst_sel", 32'(out_sel), 32'd0);
    chk("postrst_out", out_d, 32'hA000_0000);
    in_valid = 8'h40;
    step();
    chk("hold6_sel", 32'(out_sel), 32'd6);
    out_ready = 1'b0; mode = 1'b0; sel = 3'd2; in_valid = 8'h44;
    settle();
    chk("switch_ready", 32'(in_ready), 32'h0);
    step();
    chk("switch_sel_hold", 32'(out_sel), 32'd6);
    chk("switch_out_hold", out_d, 32'hA000_0006);
    out_ready = 1'b1;
    settle();
    chk("switch_ready2", 32'(in_ready), 32'h04);
    step();
    chk("switch_new_sel", 32'(out_sel), 32'd2);
    chk("switch_new_out", out_d, 32'hA000_0002);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
